// File: rtl/sha256_multiblock.sv
// SHA-256 over a fixed-length message: internal padding, block sequencing and
// chaining through one iterative compression core (64 rounds per block).

module sha256_core (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         enable,
  input  logic [511:0] data,
  input  logic [255:0] current_hash,
  output logic [255:0] hash,
  output logic         hash_done
);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  typedef enum logic [1:0] {C_IDLE, C_RUN, C_WAIT} core_state_t;
  core_state_t cs, cs_next;

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] w [16];
  logic [5:0]  rnd;
  logic [31:0] t1, t2, w_new;

  always_comb begin
    t1    = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[rnd] + w[0];
    t2    = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
          + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
  end

  // After a result the core parks in C_WAIT until enable drops, so a held
  // enable never starts a second compression.
  always_comb begin
    cs_next = cs;
    case (cs)
      C_IDLE:  if (enable) cs_next = C_RUN;
      C_RUN:   if (!enable) cs_next = C_IDLE;
               else if (rnd == 6'd63) cs_next = C_WAIT;
      C_WAIT:  if (!enable) cs_next = C_IDLE;
      default: cs_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cs <= C_IDLE;
      {a, b, c, d, e, f, g, h} <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      rnd       <= '0;
      hash      <= '0;
      hash_done <= 1'b0;
    end else begin
      cs        <= cs_next;
      hash_done <= 1'b0;
      case (cs)
        C_IDLE: if (enable) begin
          {a, b, c, d, e, f, g, h} <= current_hash;
          for (int i = 0; i < 16; i++) w[i] <= data[511-32*i -: 32];
          rnd <= '0;
        end
        C_RUN: if (enable) begin
          {b, c, d} <= {a, b, c};
          {f, g, h} <= {e, f, g};
          a <= t1 + t2;
          e <= d + t1;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_new;
          rnd   <= rnd + 6'd1;
          if (rnd == 6'd63) begin
            hash <= {current_hash[255:224] + t1 + t2, current_hash[223:192] + a,
                     current_hash[191:160] + b,       current_hash[159:128] + c,
                     current_hash[127:96]  + d + t1,  current_hash[95:64]   + e,
                     current_hash[63:32]   + f,       current_hash[31:0]    + g};
            hash_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

module sha256_multiblock #(
  parameter int MSG_BYTES        = 80,
  parameter int LEN_OFFSET_BYTES = 0
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic [8*MSG_BYTES-1:0] msg,
  input  logic [255:0]           init_hash,
  output logic                   busy,
  output logic                   done,
  output logic [255:0]           hash,
  output logic [1:0]             fsm_state
);
  localparam int          NBLK     = (MSG_BYTES + 9 + 63) / 64;
  localparam int          PW       = NBLK * 512;
  localparam int          CW       = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [63:0] LEN_BITS = 64'(8 * (MSG_BYTES + LEN_OFFSET_BYTES));

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2, FIN = 2'd3} state_t;
  state_t state, next;

  logic [8*MSG_BYTES-1:0] msg_r;
  logic [255:0]           chain_r;
  logic [CW-1:0]          cnt;
  logic [PW-1:0]          padded;
  logic [511:0]           core_data;
  logic [255:0]           core_hash;
  logic                   core_en, core_done, last;

  assign fsm_state = state;
  assign last      = (cnt == CW'(NBLK - 1));

  // Padding is built from the captured copy so msg may change after start.
  always_comb begin
    padded = '0;
    padded[PW-1 -: 8*MSG_BYTES]     = msg_r;
    padded[PW-8*MSG_BYTES-1 -: 8]   = 8'h80;
    padded[63:0]                    = LEN_BITS;
    core_data = padded[512*(NBLK-1-int'(cnt)) +: 512];
  end

  always_comb begin
    next    = state;
    busy    = 1'b0;
    done    = 1'b0;
    core_en = 1'b0;
    case (state)
      IDLE: if (start) next = RUN;
      RUN: begin
        busy    = 1'b1;
        core_en = 1'b1;
        if (core_done) next = last ? FIN : GAP;
      end
      GAP: begin
        busy = 1'b1;
        next = RUN;
      end
      FIN: begin
        busy = 1'b1;
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      msg_r   <= '0;
      chain_r <= '0;
      cnt     <= '0;
      hash    <= '0;
    end else begin
      state <= next;
      case (state)
        IDLE: if (start) begin
          msg_r   <= msg;
          chain_r <= init_hash;
          cnt     <= '0;
        end
        RUN: if (core_done) begin
          chain_r <= core_hash;
          // Digest is loaded on entry to FIN so it is already valid while done is high.
          if (last) hash <= core_hash;
          else      cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  sha256_core u_core (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (core_en),
    .data         (core_data),
    .current_hash (chain_r),
    .hash         (core_hash),
    .hash_done    (core_done)
  );
endmodule

// File: tb/tb_sha256_multiblock.sv
// Directed bench for sha256_multiblock: five parameterisations checked against
// known digests and a behavioural SHA-256 model through an expected queue.

module tb_sha256_multiblock;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         n_rst;
  logic [4:0]   start_v, busy_v, done_v, en_v;
  logic [255:0] hash_v [5];
  logic [1:0]   st_v [5];
  logic [63:0]  lenf_v [5];
  logic [255:0] ih, ih_h;
  logic [23:0]  m3;
  logic [447:0] m56;
  logic [439:0] m55;
  logic [639:0] m80, mh;
  logic [255:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  sha256_multiblock #(.MSG_BYTES(3)) u_abc (.clk(clk), .n_rst(n_rst), .start(start_v[0]), .msg(m3),
    .init_hash(ih), .busy(busy_v[0]), .done(done_v[0]), .hash(hash_v[0]), .fsm_state(st_v[0]));
  sha256_multiblock #(.MSG_BYTES(56)) u_56 (.clk(clk), .n_rst(n_rst), .start(start_v[1]), .msg(m56),
    .init_hash(ih), .busy(busy_v[1]), .done(done_v[1]), .hash(hash_v[1]), .fsm_state(st_v[1]));
  sha256_multiblock #(.MSG_BYTES(55)) u_55 (.clk(clk), .n_rst(n_rst), .start(start_v[2]), .msg(m55),
    .init_hash(ih), .busy(busy_v[2]), .done(done_v[2]), .hash(hash_v[2]), .fsm_state(st_v[2]));
  sha256_multiblock #(.MSG_BYTES(80)) u_80 (.clk(clk), .n_rst(n_rst), .start(start_v[3]), .msg(m80),
    .init_hash(ih), .busy(busy_v[3]), .done(done_v[3]), .hash(hash_v[3]), .fsm_state(st_v[3]));
  sha256_multiblock #(.MSG_BYTES(80), .LEN_OFFSET_BYTES(64)) u_hm (.clk(clk), .n_rst(n_rst),
    .start(start_v[4]), .msg(mh), .init_hash(ih_h), .busy(busy_v[4]), .done(done_v[4]),
    .hash(hash_v[4]), .fsm_state(st_v[4]));

  assign en_v   = {u_hm.core_en, u_80.core_en, u_55.core_en, u_56.core_en, u_abc.core_en};
  assign lenf_v[0] = u_abc.core_data[63:0];
  assign lenf_v[1] = u_56.core_data[63:0];
  assign lenf_v[2] = u_55.core_data[63:0];
  assign lenf_v[3] = u_80.core_data[63:0];
  assign lenf_v[4] = u_hm.core_data[63:0];

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] m_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] wv [64];
    logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, x1, x2;
    for (int i = 0; i < 16; i++) wv[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      wv[i] = (rr(wv[i-2], 17) ^ rr(wv[i-2], 19) ^ (wv[i-2] >> 10)) + wv[i-7]
            + (rr(wv[i-15], 7) ^ rr(wv[i-15], 18) ^ (wv[i-15] >> 3)) + wv[i-16];
    {va, vb, vc, vd, ve, vf, vg, vh} = hin;
    for (int i = 0; i < 64; i++) begin
      x1 = vh + (rr(ve, 6) ^ rr(ve, 11) ^ rr(ve, 25)) + ((ve & vf) ^ (~ve & vg)) + KT[i] + wv[i];
      x2 = (rr(va, 2) ^ rr(va, 13) ^ rr(va, 22)) + ((va & vb) ^ (va & vc) ^ (vb & vc));
      vh = vg; vg = vf; vf = ve; ve = vd + x1;
      vd = vc; vc = vb; vb = va; va = x1 + x2;
    end
    return {hin[255:224] + va, hin[223:192] + vb, hin[191:160] + vc, hin[159:128] + vd,
            hin[127:96] + ve, hin[95:64] + vf, hin[63:32] + vg, hin[31:0] + vh};
  endfunction

  // Message occupies the low 8*n bits of m, first byte most significant.
  function automatic logic [255:0] m_sha(input logic [1151:0] m, input int n);
    logic [7:0]   pb [192];
    logic [511:0] blk;
    logic [255:0] hh;
    logic [63:0]  lb;
    int nb;
    nb = (n + 9 + 63) / 64;
    lb = 64'(8 * n);
    for (int i = 0; i < 192; i++) pb[i] = 8'h00;
    for (int i = 0; i < n; i++) pb[i] = m[8*(n-1-i) +: 8];
    pb[n] = 8'h80;
    for (int j = 0; j < 8; j++) pb[nb*64-8+j] = lb[63-8*j -: 8];
    hh = IV;
    for (int bi = 0; bi < nb; bi++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pb[bi*64+j];
      hh = m_compress(hh, blk);
    end
    return hh;
  endfunction

  // ---------------- checking and driver tasks ----------------
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic start_pulse(input int k, input string tag);
    @(negedge clk);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    check({tag, " busy_after_start"}, 256'(busy_v[k]), 256'd1);
  endtask

  // Samples from the current negedge until done; returns on the done cycle.
  task automatic wait_done(input int k, input string tag, output logic [255:0] h,
                           output int rises, output int gaps, output logic [63:0] lenf);
    bit prev, seen;
    prev = 1'b0; seen = 1'b0; rises = 0; gaps = 0; lenf = '0; h = '0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      if (c > 0) @(negedge clk);
      if (en_v[k] && !prev) rises++;
      prev = en_v[k];
      if (busy_v[k] && !en_v[k] && st_v[k] != 2'd3) gaps++;
      if (en_v[k]) lenf = lenf_v[k];
      if (done_v[k]) begin
        seen = 1'b1;
        h = hash_v[k];
      end
    end
    check({tag, " done_seen"}, 256'(seen), 256'd1);
  endtask

  task automatic run_txn(input int k, input string tag, input logic [255:0] expv,
                         input int nblk, input logic [63:0] exp_len);
    logic [255:0] h, e;
    logic [63:0]  lf;
    int r, g;
    exp_q.push_back(expv);
    start_pulse(k, tag);
    wait_done(k, tag, h, r, g, lf);
    e = exp_q.pop_front();
    check({tag, " digest"}, h, e);
    check({tag, " length_field"}, 256'(lf), 256'(exp_len));
    check({tag, " blocks"}, 256'(r), 256'(nblk));
    check({tag, " gap_cycles"}, 256'(g), 256'(nblk - 1));
    @(negedge clk);
    check({tag, " done_single"}, 256'(done_v[k]), 256'd0);
    check({tag, " idle_after"}, 256'(busy_v[k]), 256'd0);
    check({tag, " hash_held"}, hash_v[k], e);
  endtask

  task automatic rand80(output logic [639:0] v);
    for (int i = 0; i < 20; i++) v[32*i +: 32] = $urandom();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] h, e;
    logic [63:0]  lf;
    int r, g, nd;
    bit reached;

    n_rst = 1'b0; start_v = '0;
    ih = IV; ih_h = '0;
    m3 = '0; m56 = '0; m55 = '0; m80 = '0; mh = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("reset busy%0d", k), 256'(busy_v[k]), 256'd0);
      check($sformatf("reset done%0d", k), 256'(done_v[k]), 256'd0);
      check($sformatf("reset hash%0d", k), hash_v[k], 256'd0);
    end
    n_rst = 1'b1;

    m3 = 24'h616263;
    run_txn(0, "abc", 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 1, 64'd24);

    m56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    run_txn(1, "abc56", 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, 2, 64'd448);

    m55 = '0;
    run_txn(2, "zero55", m_sha(1152'(m55), 55), 1, 64'd440);
    m56 = '0;
    run_txn(1, "zero56", m_sha(1152'(m56), 56), 2, 64'd448);
    m80 = '0;
    run_txn(3, "zero80", m_sha(1152'(m80), 80), 2, 64'd640);

    // HMAC inner stage: chaining value is the midstate of key^ipad.
    ih_h = m_compress(IV, {{32{8'h3d}}, {32{8'h36}}});
    rand80(mh);
    run_txn(4, "hmac_inner", m_sha({{32{8'h3d}}, {32{8'h36}}, mh}, 144), 2, 64'd1152);

    // Start during RUN and on the done cycle must be ignored; retry accepted.
    rand80(m80);
    exp_q.push_back(m_sha(1152'(m80), 80));
    start_pulse(3, "ign");
    repeat (15) @(negedge clk);
    rand80(m80);
    start_v[3] = 1'b1;
    @(negedge clk);
    start_v[3] = 1'b0;
    check("ign midrun_busy", 256'(busy_v[3]), 256'd1);
    wait_done(3, "ign", h, r, g, lf);
    e = exp_q.pop_front();
    check("ign digest", h, e);
    rand80(m80);
    start_v[3] = 1'b1;
    exp_q.push_back(m_sha(1152'(m80), 80));
    @(negedge clk);
    check("ign done_cycle_start", 256'(busy_v[3]), 256'd0);
    @(negedge clk);
    start_v[3] = 1'b0;
    check("retry busy", 256'(busy_v[3]), 256'd1);
    wait_done(3, "retry", h, r, g, lf);
    e = exp_q.pop_front();
    check("retry digest", h, e);
    check("retry length_field", 256'(lf), 256'd640);

    // Asynchronous reset during the second block.
    @(negedge clk);
    rand80(m80);
    start_pulse(3, "rst");
    reached = 1'b0;
    for (int c = 0; c < 500 && !reached; c++) begin
      @(negedge clk);
      if (st_v[3] == 2'd2) reached = 1'b1;
    end
    check("rst reached_gap", 256'(reached), 256'd1);
    repeat (10) @(negedge clk);
    check("rst second_block_running", 256'(en_v[3]), 256'd1);
    #2 n_rst = 1'b0;
    #1;
    check("rst busy_async", 256'(busy_v[3]), 256'd0);
    check("rst hash_async", hash_v[3], 256'd0);
    check("rst enable_dropped", 256'(en_v[3]), 256'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    nd = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (done_v[3]) nd++;
    end
    check("rst no_done", 256'(nd), 256'd0);
    rand80(m80);
    run_txn(3, "post_rst", m_sha(1152'(m80), 80), 2, 64'd640);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
